// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller.
//   spi_state_e    : frame sequencer states
//   DEF_FRAME_BITS : default frame length (24-bit shift-register slave)
//   DEF_CLK_DIV    : default clk cycles per SCK half-period
//   max3()         : sizes the shared phase timer
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_LO,
    SCK_HI,
    HOLD
  } spi_state_e;

  localparam int DEF_FRAME_BITS = 24;
  localparam int DEF_CLK_DIV    = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_sck_timer.sv
// Loadable down-counter used for every SPI phase interval (CS setup, SCK
// half-periods, CS hold).
//   clk, reset_n : system clock, async active-low reset
//   load         : start a new interval; load_val = interval length - 1
//   expire       : one-cycle pulse on the final cycle of the interval
// A load on the expire cycle chains straight into the next interval with no
// gap, which is how consecutive phases stay exactly their nominal length.
module spi_sck_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic         armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (armed) begin
      if (cnt == '0) armed <= 1'b0;
      else           cnt   <= cnt - W'(1);
    end
  end

  // armed keeps expire from sitting high while the sequencer is idle
  assign expire = armed && (cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-master SPI frame sequencer for the serial shift-register slave.
//   clk, reset_n : system clock, async active-low reset
//   start        : frame request, accepted only in IDLE
//   tx_data      : word to send, captured when start is accepted
//   busy         : frame in progress
//   done         : one-cycle pulse in the first IDLE cycle, rx_data valid
//   rx_data      : last received word, held until the next done
//   pad_cs       : chip select (active high) framing the transfer
//   pad_sck      : serial clock, idle low
//   pad_din      : serial data to slave, MSB first
//   pad_dout     : serial data from slave, captured MSB first
// Every output is a flop loaded from the next-state decode, so the pads are
// glitch-free and line up cycle-exactly with the FSM state.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int CS_SETUP   = 1,
  parameter int CS_HOLD    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  pad_cs,
  output logic                  pad_sck,
  output logic                  pad_din,
  input  logic                  pad_dout
);

  // one timer covers all phases, so it is sized for the longest one
  localparam int TMAX = max3(CLK_DIV, CS_SETUP, CS_HOLD);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(FRAME_BITS + 1);

  spi_state_e state, state_nxt;

  logic [FRAME_BITS-1:0] tx_sh, tx_sh_nxt;
  logic [FRAME_BITS-1:0] rx_sh, rx_sh_nxt;
  logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
  logic                  accept;
  logic                  shift;
  logic                  tmr_load;
  logic [TW-1:0]         tmr_val;
  logic                  tmr_expire;

  spi_sck_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // next-state
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shift     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP:  if (tmr_expire) state_nxt = SCK_LO;
      SCK_LO: if (tmr_expire) state_nxt = SCK_HI;
      SCK_HI: begin
        // end of the high phase: slave has seen the rise, move to next bit
        if (tmr_expire) begin
          shift     = 1'b1;
          state_nxt = (bit_cnt == BW'(1)) ? HOLD : SCK_LO;
        end
      end
      HOLD:    if (tmr_expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // every state change starts a fresh interval for the state being entered
  always_comb begin
    tmr_load = (state_nxt != state);
    tmr_val  = '0;
    case (state_nxt)
      SETUP:          tmr_val = TW'(CS_SETUP - 1);
      SCK_LO, SCK_HI: tmr_val = TW'(CLK_DIV - 1);
      HOLD:           tmr_val = TW'(CS_HOLD - 1);
      default:        tmr_val = '0;
    endcase
  end

  // shift-register / bit counter datapath
  always_comb begin
    tx_sh_nxt   = tx_sh;
    rx_sh_nxt   = rx_sh;
    bit_cnt_nxt = bit_cnt;
    if (accept) begin
      tx_sh_nxt   = tx_data;
      rx_sh_nxt   = '0;
      bit_cnt_nxt = BW'(FRAME_BITS);
    end else if (shift) begin
      tx_sh_nxt   = tx_sh << 1;
      rx_sh_nxt   = (rx_sh << 1) | FRAME_BITS'(pad_dout);
      bit_cnt_nxt = bit_cnt - BW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tx_sh   <= tx_sh_nxt;
      rx_sh   <= rx_sh_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // registered outputs decoded from the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      pad_cs  <= 1'b0;
      pad_sck <= 1'b0;
      pad_din <= 1'b0;
    end else begin
      busy    <= (state_nxt != IDLE);
      pad_cs  <= (state_nxt != IDLE);
      pad_sck <= (state_nxt == SCK_HI);
      // din changes only on accept or at the end of SCK_HI, i.e. with a fall
      pad_din <= (state_nxt != IDLE) && tx_sh_nxt[FRAME_BITS-1];
      done    <= (state == HOLD) && (state_nxt == IDLE);
      if ((state == HOLD) && (state_nxt == IDLE)) rx_data <= rx_sh;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: default instance (24b, div 2) and a
// short-frame instance (8b, div 1, setup/hold 3). A cycle monitor (tick)
// plays the slave and records pad_din bits, busy length, SCK period and
// chip-select gaps for the selected instance.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_start, a_busy, a_done, a_cs, a_sck, a_din, a_dout;
  logic [23:0] a_tx, a_rx;
  logic        b_start, b_busy, b_done, b_cs, b_sck, b_din, b_dout;
  logic [7:0]  b_tx, b_rx;

  spi_master_ctrl u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .tx_data(a_tx),
    .busy(a_busy), .done(a_done), .rx_data(a_rx),
    .pad_cs(a_cs), .pad_sck(a_sck), .pad_din(a_din), .pad_dout(a_dout)
  );

  spi_master_ctrl #(.FRAME_BITS(8), .CLK_DIV(1), .CS_SETUP(3), .CS_HOLD(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .tx_data(b_tx),
    .busy(b_busy), .done(b_done), .rx_data(b_rx),
    .pad_cs(b_cs), .pad_sck(b_sck), .pad_din(b_din), .pad_dout(b_dout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // monitor state (written only by the main process through tick)
  logic        sel = 1'b0;
  logic        busy_q = 1'b0, cs_q = 1'b0, sck_q = 1'b0, done_busy_q = 1'b0;
  int          busy_run = 0, last_busy = 0, n_done = 0, n_cs = 0;
  int          cs_low = 0, last_gap = 0, idx = 0, cyc = 0, last_rise = 0, sck_per = 0;
  logic [23:0] din_cap = '0, slv_word = '0;
  logic        ok;
  int          d0, c0, prev;

  wire m_busy = sel ? b_busy : a_busy;
  wire m_done = sel ? b_done : a_done;
  wire m_cs   = sel ? b_cs   : a_cs;
  wire m_sck  = sel ? b_sck  : a_sck;
  wire m_din  = sel ? b_din  : a_din;

  task automatic tick();
    int fb;
    @(negedge clk);
    cyc++;
    fb = sel ? 8 : 24;
    if (m_done) begin
      n_done++;
      done_busy_q = busy_q;
    end
    if (m_busy) busy_run++;
    else if (busy_q) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
    if (m_cs && !cs_q) begin
      n_cs++;
      last_gap = cs_low;
      idx      = 0;
      din_cap  = '0;
    end
    cs_low = m_cs ? 0 : cs_low + 1;
    // slave: capture din and present the next dout bit on each SCK rise
    if (m_sck && !sck_q) begin
      sck_per   = cyc - last_rise;
      last_rise = cyc;
      if (idx < fb) begin
        din_cap[fb-1-idx] = m_din;
        if (sel) b_dout = slv_word[fb-1-idx];
        else     a_dout = slv_word[fb-1-idx];
        idx++;
      end
    end
    busy_q = m_busy;
    cs_q   = m_cs;
    sck_q  = m_sck;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n0;
    logic seen;
    n0   = n_done;
    seen = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      tick();
      if (n_done != n0) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_start = 0; a_tx = '0; a_dout = 0;
    b_start = 0; b_tx = '0; b_dout = 0;

    // reset state
    repeat (3) tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_rx",   a_rx,   0);
    chk("rst_cs",   a_cs,   0);
    chk("rst_sck",  a_sck,  0);
    chk("rst_din",  a_din,  0);
    chk("rst_b_cs", b_cs,   0);
    reset_n = 1'b1;
    repeat (2) tick();

    // 1/2: single frame, tx pattern on din, slave word into rx_data
    slv_word = 24'h5A0F3C;
    a_tx = 24'hA5C3F0; a_start = 1;
    tick();
    chk("t1_busy_on", a_busy, 1);
    a_start = 0; a_tx = 24'h000000;   // late change must not matter
    wait_done("t1", 200);
    chk("t1_din_seq",    din_cap,     24'hA5C3F0);
    chk("t1_busy_len",   last_busy,   98);
    chk("t1_busy_at_done", a_busy,    0);
    chk("t1_busy_before_done", done_busy_q, 1);
    chk("t1_sck_period", sck_per,     4);
    chk("t1_rx",         a_rx,        24'h5A0F3C);
    tick();
    chk("t1_done_1cyc",  a_done,      0);
    repeat (5) tick();
    chk("t1_rx_hold",    a_rx,        24'h5A0F3C);

    // 3: start held high -> back-to-back frames, 1-cycle cs gap
    slv_word = 24'h96E1D2;
    a_tx = 24'h3C3C3C; a_start = 1;
    d0 = n_done; c0 = n_cs; prev = n_cs; ok = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (n_cs != prev && n_cs - c0 >= 2) chk("t3_cs_gap", last_gap, 1);
      prev = n_cs;
      if (n_done - d0 == 3) begin
        a_start = 0;
        ok = 1;
        break;
      end
    end
    chk("t3_three_done", ok, 1);
    repeat (150) tick();
    chk("t3_frames", n_cs - c0,   3);
    chk("t3_dones",  n_done - d0, 3);
    chk("t3_rx",     a_rx,        24'h96E1D2);
    chk("t3_din",    din_cap,     24'h3C3C3C);
    chk("t3_idle_cs", a_cs,       0);

    // 4: reset mid-frame at bit 10
    slv_word = 24'h000000;
    a_tx = 24'hFFFFFF; a_start = 1;
    tick();
    a_start = 0;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (idx >= 10) begin
        ok = 1;
        break;
      end
    end
    chk("t4_reach_bit10", ok, 1);
    d0 = n_done;
    reset_n = 1'b0;
    #1;
    chk("t4_cs_async",   a_cs,   0);
    chk("t4_sck_async",  a_sck,  0);
    chk("t4_busy_async", a_busy, 0);
    chk("t4_rx_clear",   a_rx,   0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("t4_no_done", n_done - d0, 0);
    slv_word = 24'hE1B4C7;
    a_tx = 24'h0F1E2D; a_start = 1;
    tick();
    a_start = 0;
    wait_done("t4_after", 200);
    chk("t4_din",      din_cap,   24'h0F1E2D);
    chk("t4_rx",       a_rx,      24'hE1B4C7);
    chk("t4_busy_len", last_busy, 98);

    // 5: short-frame instance, div 1, setup/hold 3
    sel = 1'b1;
    repeat (2) tick();
    slv_word = 24'h00003C;
    b_tx = 8'h81; b_start = 1;
    tick();
    b_start = 0;
    wait_done("t5", 100);
    chk("t5_din",        din_cap,   24'h000081);
    chk("t5_busy_len",   last_busy, 22);
    chk("t5_sck_period", sck_per,   2);
    chk("t5_rx",         b_rx,      8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
